// File: rtl/btn_cmd_arbiter_if.sv
// Command port between the request arbiter and the processor front-end decoder.
// A command is transferred on each clock edge where cmd_valid and cmd_ready are both high.
interface btn_cmd_arbiter_if #(
  parameter int ID_W = 2
) ();
  logic            cmd_valid;
  logic [ID_W-1:0] cmd_id;
  logic            cmd_ready;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/btn_cmd_arbiter.sv
// Per-channel edge-to-pulse request capture, pending flags and a round-robin grant onto one command port.
// Optional input debounce is compiled in when the macro BTN_DEBOUNCE_EN is defined.
module btn_cmd_chan #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  output logic o_evt
);
  logic r_s, r_p;

`ifdef BTN_DEBOUNCE_EN
  logic [DB_W-1:0] r_cnt;

  // A level change only reaches r_s after DB_CYCLES consecutive cycles of mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s   <= 1'b0;
      r_cnt <= '0;
    end else if (i_req != r_s) begin
      if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
        r_s   <= i_req;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) r_s <= 1'b0;
    else     r_s <= i_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_p <= 1'b0;
    else     r_p <= r_s;
  end

  assign o_evt = r_s & ~r_p;
endmodule

module btn_cmd_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     i_req_in,
  btn_cmd_arbiter_if.master    cmd,
  output logic [N_REQ-1:0]     o_pending,
  output logic                 o_overrun
);
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT = 2'b01} state_t;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_cmd_id, w_cmd_id_nxt;
  logic [ID_W-1:0]   r_last_grant, w_last_nxt;
  logic [N_REQ-1:0]  r_pending;
  logic              r_overrun;
  logic [N_REQ-1:0]  w_evt, w_clr, w_drop;
  logic              w_hs, w_found;
  logic [ID_W-1:0]   w_pick;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_chan
      btn_cmd_chan #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_chan (
        .clk   (clk),
        .rst   (rst),
        .i_req (i_req_in[gi]),
        .o_evt (w_evt[gi])
      );
      assign w_clr[gi] = w_hs & (r_cmd_id == ID_W'(gi));
    end
  endgenerate

  assign w_hs   = (r_state == GRANT) & cmd.cmd_ready;
  // A new event on a channel that stays pending is lost; a concurrent clear does not count as a drop.
  assign w_drop = w_evt & r_pending & ~w_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_pending <= w_evt | (r_pending & ~w_clr);
      r_overrun <= |w_drop;
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    logic [ID_W:0] idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, r_last_grant} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!w_found && r_pending[idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_id_nxt = r_cmd_id;
    w_last_nxt   = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt  = GRANT;
          w_cmd_id_nxt = w_pick;
        end
      end
      GRANT: begin
        if (cmd.cmd_ready) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_cmd_id;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cmd_id     <= '0;
      r_last_grant <= ID_W'(N_REQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_cmd_id     <= w_cmd_id_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  assign cmd.cmd_valid = (r_state == GRANT);
  assign cmd.cmd_id    = r_cmd_id;
  assign o_pending     = r_pending;
  assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Directed bench for btn_cmd_arbiter; debounce scenario is selected by BTN_DEBOUNCE_EN.
module tb_btn_cmd_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] pend;
  logic       ovr;
  int         nvec = 0;
  int         nerr = 0;

  btn_cmd_arbiter_if #(.ID_W(2)) cmd_if ();

  btn_cmd_arbiter #(.N_REQ(4), .ID_W(2), .DB_CYCLES(16), .DB_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req_in  (req),
    .cmd       (cmd_if.master),
    .o_pending (pend),
    .o_overrun (ovr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_p [10];
    int         ov_cnt;
    rst = 1'b1;
    req = 4'b0000;
    cmd_if.cmd_ready = 1'b1;
    do_reset();
    chk("rst_valid", 32'(cmd_if.cmd_valid), 0);
    chk("rst_id", 32'(cmd_if.cmd_id), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_ovr", 32'(ovr), 0);

`ifndef BTN_DEBOUNCE_EN
    // 1: single held request on channel 2
    req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("t1_valid_%0d", k), 32'(cmd_if.cmd_valid), (k == 2) ? 1 : 0);
      if (k == 2) chk("t1_id", 32'(cmd_if.cmd_id), 2);
      chk($sformatf("t1_pend_%0d", k), 32'(pend), (k == 1 || k == 2) ? 4 : 0);
    end
    req = 4'b0000;
    step(); step();

    // 2: all four rise together
    do_reset();
    exp_p = '{4'b0000, 4'b1111, 4'b1111, 4'b1110, 4'b1110,
              4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000};
    req = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("t2_valid_%0d", k), 32'(cmd_if.cmd_valid),
          (k >= 2 && k % 2 == 0) ? 1 : 0);
      if (k >= 2 && k % 2 == 0) chk($sformatf("t2_id_%0d", k), 32'(cmd_if.cmd_id), 32'((k - 2) / 2));
      chk($sformatf("t2_pend_%0d", k), 32'(pend), 32'(exp_p[k]));
      chk($sformatf("t2_ovr_%0d", k), 32'(ovr), 0);
    end
    req = 4'b0000;
    step(); step();

    // 3: stalled grant on channel 1 with two dropped re-triggers
    do_reset();
    cmd_if.cmd_ready = 1'b0;
    req = 4'b0010;
    step(); step(); step();
    chk("t3_valid0", 32'(cmd_if.cmd_valid), 1);
    chk("t3_id0", 32'(cmd_if.cmd_id), 1);
    ov_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      req = ((j >= 3 && j <= 5) || (j >= 9 && j <= 11)) ? 4'b0010 : 4'b0000;
      step();
      chk($sformatf("t3_valid_%0d", j), 32'(cmd_if.cmd_valid), 1);
      chk($sformatf("t3_id_%0d", j), 32'(cmd_if.cmd_id), 1);
      if (ovr) ov_cnt++;
    end
    chk("t3_ovr_pulses", 32'(ov_cnt), 2);
    cmd_if.cmd_ready = 1'b1;
    step();
    chk("t3_valid_done", 32'(cmd_if.cmd_valid), 0);
    chk("t3_pend_done", 32'(pend), 0);
    step(); step();
    chk("t3_no_second", 32'(cmd_if.cmd_valid), 0);

    // 4: event on channel 3 in the same cycle as its handshake
    do_reset();
    cmd_if.cmd_ready = 1'b0;
    req = 4'b1000;
    step(); step(); step();
    chk("t4_id3", 32'(cmd_if.cmd_id), 3);
    req = 4'b0001;
    step(); step();
    chk("t4_pend_a", 32'(pend), 4'b1001);
    req = 4'b1001;
    step();
    cmd_if.cmd_ready = 1'b1;
    step();
    chk("t4_valid_hs", 32'(cmd_if.cmd_valid), 0);
    chk("t4_pend_setwins", 32'(pend), 4'b1001);
    chk("t4_ovr_hs", 32'(ovr), 0);
    step();
    chk("t4_grant0_v", 32'(cmd_if.cmd_valid), 1);
    chk("t4_grant0_id", 32'(cmd_if.cmd_id), 0);
    chk("t4_ovr_next", 32'(ovr), 0);
    step();
    chk("t4_pend_b", 32'(pend), 4'b1000);
    step();
    chk("t4_grant3_v", 32'(cmd_if.cmd_valid), 1);
    chk("t4_grant3_id", 32'(cmd_if.cmd_id), 3);
    step();
    chk("t4_pend_end", 32'(pend), 0);
    req = 4'b0000;
    step(); step();

    // 5: reset during GRANT
    do_reset();
    cmd_if.cmd_ready = 1'b0;
    req = 4'b0100;
    step(); step(); step();
    chk("t5_valid_pre", 32'(cmd_if.cmd_valid), 1);
    rst = 1'b1;
    req = 4'b0000;
    step();
    chk("t5_valid_rst", 32'(cmd_if.cmd_valid), 0);
    chk("t5_pend_rst", 32'(pend), 0);
    rst = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t5_idle_%0d", k), 32'(cmd_if.cmd_valid), 0);
    end
    req = 4'b0100;
    step(); step(); step();
    chk("t5_new_v", 32'(cmd_if.cmd_valid), 1);
    chk("t5_new_id", 32'(cmd_if.cmd_id), 2);
`else
    // 6: debounce rejects a 10-cycle glitch, accepts a 20-cycle pulse
    req = 4'b0001;
    for (int k = 0; k < 30; k++) begin
      if (k == 10) req = 4'b0000;
      step();
      chk($sformatf("t6g_valid_%0d", k), 32'(cmd_if.cmd_valid), 0);
      chk($sformatf("t6g_pend_%0d", k), 32'(pend), 0);
    end
    req = 4'b0001;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) req = 4'b0000;
      step();
      chk($sformatf("t6_valid_%0d", k), 32'(cmd_if.cmd_valid), (k == 17) ? 1 : 0);
      if (k == 17) chk("t6_id", 32'(cmd_if.cmd_id), 0);
      chk($sformatf("t6_pend_%0d", k), 32'(pend), (k == 16 || k == 17) ? 1 : 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
